sigmoid_issue_ctrl: RTL and testbench

//  Valid/ready front end for the multi-cycle sigmoid_approx core, which has no handshake of its own.

---
 rtl/sigmoid_pkg.sv | 28 ++
 rtl/sigmoid_in_fifo.sv | 55 +++++
 rtl/sigmoid_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_sigmoid_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared definitions for the sigmoid issue controller and its input buffer.
// Holds the operand geometry, the special-value results returned without
// the core, exception flag bit positions and the controller state type.
package sigmoid_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;            // hidden bit included
  localparam int unsigned W      = EXP_W + MANT_W;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned EXC_W  = 5;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ONE  = 32'h3F800000;

  // Flag order matches the core: {invalid, infinite, overflow, underflow, inexact}
  localparam int unsigned EXC_INVALID   = 4;
  localparam int unsigned EXC_INFINITE  = 3;
  localparam int unsigned EXC_OVERFLOW  = 2;
  localparam int unsigned EXC_UNDERFLOW = 1;
  localparam int unsigned EXC_INEXACT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } sig_ctrl_state_t;

endpackage

// File: rtl/sigmoid_in_fifo.sv
// Synchronous FIFO buffering operands ahead of the sigmoid core.
// Ports: push/wdata write, pop/rdata read (rdata shows the head entry),
// full/empty status, count = current occupancy. Push when full and pop
// when empty are ignored. DEPTH must be a power of two so pointers wrap
// naturally modulo DEPTH.
module sigmoid_in_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sigmoid_issue_ctrl.sv
// Valid/ready front end for the multi-cycle sigmoid core, which has no
// handshake of its own. Operands are buffered, issued one at a time with
// core_x held for LATENCY cycles, and results returned in input order.
// NaN and infinity operands skip the core and are resolved locally.
// Ports:
//   clk, rst_l                      clock, async active-low reset
//   in_valid/in_ready/in_x/in_round_mode   operand input (valid/ready)
//   core_x/core_round_mode          registered operand to the core
//   core_sigmoid/core_exceptions    core result, sampled after LATENCY cycles
//   out_valid/out_ready/out_sigmoid/out_exceptions  result output (valid/ready)
module sigmoid_issue_ctrl
  import sigmoid_pkg::*;
#(
  parameter int unsigned exp_width  = EXP_W,
  parameter int unsigned mant_width = MANT_W,
  parameter int unsigned LATENCY    = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] in_x,
  input  logic [RM_W-1:0]                 in_round_mode,
  output logic [exp_width+mant_width-1:0] core_x,
  output logic [RM_W-1:0]                 core_round_mode,
  input  logic [exp_width+mant_width-1:0] core_sigmoid,
  input  logic [EXC_W-1:0]                core_exceptions,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] out_sigmoid,
  output logic [EXC_W-1:0]                out_exceptions
);

  localparam int unsigned OW     = exp_width + mant_width;
  localparam int unsigned FW     = OW + RM_W;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  // Special results in the operand's own format
  localparam logic [OW-1:0] QNAN_L = {1'b0, {exp_width{1'b1}}, 1'b1, {(mant_width-2){1'b0}}};
  localparam logic [OW-1:0] ONE_L  = {2'b00, {(exp_width-1){1'b1}}, {(mant_width-1){1'b0}}};

  sig_ctrl_state_t   state;
  logic [CNT_W-1:0]  count;

  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  logic [OW-1:0]     head_x;
  logic [RM_W-1:0]   head_rm;
  logic              pop_c;
  logic              head_special_c;
  logic              head_nan_c;
  logic [OW-1:0]     byp_sig_c;
  logic [EXC_W-1:0]  byp_exc_c;

  assign in_ready = !fifo_full;

  sigmoid_in_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (in_valid),
    .wdata ({in_round_mode, in_x}),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_rm, head_x} = fifo_rdata;

  // The FSM takes the next operand when idle, or when the held result is accepted
  assign pop_c = !fifo_empty && ((state == IDLE) || ((state == DONE) && out_ready));

  // Exponent all ones: NaN or infinity, resolved without the core
  assign head_special_c = &head_x[OW-2 -: exp_width];
  assign head_nan_c     = head_special_c && (head_x[mant_width-2:0] != '0);

  // Bypass result; a NaN with the quiet bit clear is signalling and raises invalid
  always_comb begin
    byp_sig_c = '0;
    byp_exc_c = '0;
    if (head_nan_c) begin
      byp_sig_c              = QNAN_L;
      byp_exc_c[EXC_INVALID] = !head_x[mant_width-2];
    end else if (!head_x[OW-1]) begin
      byp_sig_c = ONE_L;
    end
  end

  // Issue FSM: core_x only changes on HOLD entry and stays put for the whole HOLD
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      count           <= '0;
      core_x          <= '0;
      core_round_mode <= '0;
      out_valid       <= 1'b0;
      out_sigmoid     <= '0;
      out_exceptions  <= '0;
    end else if (pop_c) begin
      if (head_special_c) begin
        state          <= DONE;
        out_valid      <= 1'b1;
        out_sigmoid    <= byp_sig_c;
        out_exceptions <= byp_exc_c;
      end else begin
        state           <= HOLD;
        out_valid       <= 1'b0;
        core_x          <= head_x;
        core_round_mode <= head_rm;
        count           <= CNT_W'(LATENCY - 1);
      end
    end else begin
      unique case (state)
        HOLD: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            state          <= DONE;
            out_valid      <= 1'b1;
            out_sigmoid    <= core_sigmoid;
            out_exceptions <= core_exceptions;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer status flags must agree with its occupancy
  assert property (@(posedge clk) disable iff (!rst_l)
                   fifo_full == (fifo_count == FCNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_sigmoid_issue_ctrl.sv
// Self-checking bench for sigmoid_issue_ctrl. A behavioural stand-in for
// the sigmoid core only produces a valid result once its operand has been
// held for LATENCY-1 sampled cycles; a scoreboard predicts every result
// from the operand rules and checks the output stream in order.
`timescale 1ns/1ps
module tb_sigmoid_issue_ctrl;
  import sigmoid_pkg::*;

  localparam int LAT   = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_l = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [RM_W-1:0]  in_round_mode;
  logic [W-1:0]     core_x;
  logic [RM_W-1:0]  core_round_mode;
  logic [W-1:0]     core_sigmoid;
  logic [EXC_W-1:0] core_exceptions;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sigmoid;
  logic [EXC_W-1:0] out_exceptions;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  sigmoid_issue_ctrl #(
    .exp_width  (EXP_W),
    .mant_width (MANT_W),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_x            (in_x),
    .in_round_mode   (in_round_mode),
    .core_x          (core_x),
    .core_round_mode (core_round_mode),
    .core_sigmoid    (core_sigmoid),
    .core_exceptions (core_exceptions),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sigmoid     (out_sigmoid),
    .out_exceptions  (out_exceptions)
  );

  // Stand-in core function: {exceptions, sigmoid}; x=0, rm=0 gives 0.5
  function automatic logic [36:0] core_fn(input logic [31:0] x, input logic [2:0] rm);
    return {x[4:0] ^ {2'b00, rm}, (x ^ 32'h3F000000) + {29'd0, rm}};
  endfunction

  // Core stand-in: garbage until the operand has been stable long enough
  logic [34:0] last_op = '0;
  int          held    = 0;
  logic [36:0] core_out;
  always @(negedge clk) begin
    if ({core_round_mode, core_x} != last_op) begin
      held    <= 0;
      last_op <= {core_round_mode, core_x};
    end else begin
      held <= held + 1;
    end
  end
  assign core_out        = core_fn(core_x, core_round_mode);
  assign core_sigmoid    = (held >= LAT - 1) ? core_out[31:0]  : 32'hDEADBEEF;
  assign core_exceptions = (held >= LAT - 1) ? core_out[36:32] : 5'b11111;

  // Expected result of one operand from the bypass rules or the core
  function automatic logic [36:0] ref_fn(input logic [31:0] x, input logic [2:0] rm);
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) return {(x[22] ? 5'b00000 : 5'b10000), QNAN};
      if (x[31]) return {5'b00000, 32'h00000000};
      return {5'b00000, ONE};
    end
    return core_fn(x, rm);
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'hFF;
      1: r = {r[31], 8'hFF, 23'd0};
      2: r[30:23] = 8'h00;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: record handshakes mid-cycle, then step past the next rising edge
  task automatic tick();
    logic [36:0] e;
    @(negedge clk);
    if (in_valid && in_ready) exp_q.push_back(ref_fn(in_x, in_round_mode));
    if (out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h/%b with no result pending", out_sigmoid, out_exceptions);
      end else begin
        e = exp_q.pop_front();
        if ({out_exceptions, out_sigmoid} !== e) begin
          n_err++;
          $display("FAIL sb_result: got %b/%h required %b/%h", out_exceptions, out_sigmoid, e[36:32], e[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 800; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL %s_drain: pending %0d out_valid %b required 0/0", name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_x = '0; in_round_mode = '0; out_ready = 1'b0;
    #1 rst_l = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (core_x !== '0) begin n_err++; $display("FAIL rst_core_x: got %h required 0", core_x); end
    n_cmp++; if (core_round_mode !== '0) begin n_err++; $display("FAIL rst_core_rm: got %b required 0", core_round_mode); end
    n_cmp++; if (out_sigmoid !== '0) begin n_err++; $display("FAIL rst_out_sigmoid: got %h required 0", out_sigmoid); end
    n_cmp++; if (out_exceptions !== '0) begin n_err++; $display("FAIL rst_out_exc: got %b required 0", out_exceptions); end
    @(posedge clk); #1 rst_l = 1'b1;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_single_latency();
    int lat;
    out_ready = 1'b1; in_x = 32'h00000000; in_round_mode = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d required %0d", lat, LAT + 1); end
    n_cmp++; if (out_sigmoid !== 32'h3F000000) begin n_err++; $display("FAIL single_value: got %h required 3f000000", out_sigmoid); end
    drain("single");
  endtask

  task automatic test_bypass();
    logic [31:0] xs [4];
    logic [31:0] rs [4];
    logic [4:0]  fs [4];
    xs[0] = 32'h7F800001; rs[0] = 32'h7FC00000; fs[0] = 5'b10000;
    xs[1] = 32'hFF800000; rs[1] = 32'h00000000; fs[1] = 5'b00000;
    xs[2] = 32'h7F800000; rs[2] = 32'h3F800000; fs[2] = 5'b00000;
    xs[3] = 32'hFFC00001; rs[3] = 32'h7FC00000; fs[3] = 5'b00000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = xs[i]; in_round_mode = 3'($urandom); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bypass_latency%0d: got %b required 1", i, out_valid); end
      n_cmp++; if (out_sigmoid !== rs[i] || out_exceptions !== fs[i]) begin
        n_err++; $display("FAIL bypass_value%0d: got %h/%b required %h/%b", i, out_sigmoid, out_exceptions, rs[i], fs[i]);
      end
      tick();
    end
    drain("bypass");
  endtask

  task automatic test_round_mode();
    int seen1, seen2;
    logic [31:0] x1, x2;
    x1 = 32'h3F000001; x2 = 32'h3F000002;
    seen1 = 0; seen2 = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 90; k++) begin
      in_valid = (k < 2);
      in_x = (k == 0) ? x1 : x2;
      in_round_mode = (k == 0) ? 3'b001 : 3'b000;
      tick();
      if (core_x === x1) begin
        seen1++;
        n_cmp++; if (core_round_mode !== 3'b001) begin n_err++; $display("FAIL rm_first: got %b required 001", core_round_mode); end
      end else if (core_x === x2) begin
        seen2++;
        n_cmp++; if (core_round_mode !== 3'b000) begin n_err++; $display("FAIL rm_second: got %b required 000", core_round_mode); end
      end
    end
    n_cmp++; if (seen1 < LAT || seen2 < LAT) begin n_err++; $display("FAIL rm_hold: got %0d/%0d cycles required >=%0d each", seen1, seen2, LAT); end
    drain("round_mode");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    int t_prev, n_seen, acc;
    vals[0] = 32'hC0A00000; vals[1] = 32'hBF800000; vals[2] = 32'h00000000;
    vals[3] = 32'h3F800000; vals[4] = 32'h40A00000;
    out_ready = 1'b1; in_round_mode = 3'b000;
    for (int i = 0; i < 5; i++) begin
      in_x = vals[i]; in_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 10 && acc == 0; k++) begin
        acc = in_ready ? 1 : 0;
        tick();
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL burst_full: in_ready got %b required 0", in_ready); end
    t_prev = -1; n_seen = 0;
    for (int k = 0; k < 5 * (LAT + 1) + 60 && n_seen < 5; k++) begin
      tick();
      if (out_valid) begin
        if (t_prev >= 0) begin
          n_cmp++; if (cyc - t_prev != LAT + 1) begin n_err++; $display("FAIL burst_spacing: got %0d required %0d", cyc - t_prev, LAT + 1); end
        end
        t_prev = cyc; n_seen++;
      end
    end
    n_cmp++; if (n_seen != 5) begin n_err++; $display("FAIL burst_count: got %0d required 5", n_seen); end
    drain("burst");
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_s;
    logic [4:0]  snap_e;
    int acc, stable_bad;
    out_ready = 1'b0;
    in_x = {1'b0, 8'h7E, 23'($urandom)}; in_round_mode = 3'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && !out_valid; k++) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: out_valid got %b required 1", out_valid); end
    snap_s = out_sigmoid; snap_e = out_exceptions;
    acc = 0; stable_bad = 0;
    for (int k = 0; k < 100; k++) begin
      in_x = rand_x(); in_round_mode = 3'($urandom); in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
      if (out_valid !== 1'b1 || out_sigmoid !== snap_s || out_exceptions !== snap_e) stable_bad++;
    end
    in_valid = 1'b0;
    n_cmp++; if (stable_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles required 0", stable_bad); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (acc != DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d required %0d", acc, DEPTH); end
    drain("backpressure");
  endtask

  task automatic test_random();
    int acc;
    acc = 0;
    for (int k = 0; k < 4000 && acc < 30; k++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_x = rand_x(); in_round_mode = 3'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      if (in_valid && in_ready) acc++;
      tick();
    end
    n_cmp++; if (acc != 30) begin n_err++; $display("FAIL random_accept: got %0d required 30", acc); end
    drain("random");
  endtask

  task automatic test_reset_mid();
    logic [31:0] xs [4];
    int emitted;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) xs[i] = {1'b0, 8'h70 + 8'(i), 23'($urandom) | 23'd1};
    for (int i = 0; i < 4; i++) begin
      in_x = xs[i]; in_round_mode = 3'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (core_x !== xs[0]) begin n_err++; $display("FAIL mid_issue: core_x got %h required %h", core_x, xs[0]); end
    // HOLD entered three edges ago with count LAT-1; stop when count is 10
    for (int k = 0; k < LAT - 1 - 10 - 2; k++) tick();
    #2 rst_l = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++; if (out_valid !== 1'b0 || core_x !== '0 || core_round_mode !== '0) begin
      n_err++; $display("FAIL mid_async: got valid %b core_x %h rm %b required 0", out_valid, core_x, core_round_mode);
    end
    n_cmp++; if (out_sigmoid !== '0 || out_exceptions !== '0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_outputs: got %h/%b in_ready %b required 0/0/1", out_sigmoid, out_exceptions, in_ready);
    end
    tick(); tick();
    rst_l = 1'b1;
    emitted = 0;
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      tick();
      if (out_valid) emitted++;
    end
    n_cmp++; if (emitted != 0) begin n_err++; $display("FAIL mid_emitted: got %0d required 0", emitted); end
    n_cmp++; if (core_x !== '0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_flushed: core_x %h in_ready %b required 0/1", core_x, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_bypass();
    test_round_mode();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL end_pending: got %0d required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
